// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, the scan control bundle and width helpers.
package vga_timing_pkg;

  localparam int unsigned DEF_H_VIS  = 640;
  localparam int unsigned DEF_H_FP   = 16;
  localparam int unsigned DEF_H_SYNC = 96;
  localparam int unsigned DEF_H_BP   = 48;
  localparam int unsigned DEF_V_VIS  = 480;
  localparam int unsigned DEF_V_FP   = 10;
  localparam int unsigned DEF_V_SYNC = 2;
  localparam int unsigned DEF_V_BP   = 33;

  localparam int unsigned H_TOT = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOT = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam logic        SYNC_ACTIVE = 1'b0;
  localparam int unsigned FB_WORDS    = 307200;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned RGB_W  = 12;
  localparam int unsigned CH_W   = 4;

  // Per-pixel control bundle that travels alongside the VRAM read.
  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
    logic fs;
  } scan_ctl_t;

  localparam int unsigned CTL_W = $bits(scan_ctl_t);
  localparam scan_ctl_t CTL_IDLE = '{vis: 1'b0, hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE, fs: 1'b0};

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous clear to a programmable value.
module vga_delay_line
  import vga_timing_pkg::*;
#(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_sr[i] <= RST_VAL;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < int'(DEPTH); i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan engine: timing counters, linear VRAM read address and a pipeline
// that lines the returned RGB word up with delayed sync/blank/frame markers.
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VIS  = DEF_H_VIS,
  parameter int unsigned H_FP   = DEF_H_FP,
  parameter int unsigned H_SYNC = DEF_H_SYNC,
  parameter int unsigned H_BP   = DEF_H_BP,
  parameter int unsigned V_VIS  = DEF_V_VIS,
  parameter int unsigned V_FP   = DEF_V_FP,
  parameter int unsigned V_SYNC = DEF_V_SYNC,
  parameter int unsigned V_BP   = DEF_V_BP,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              IO_VGA_CLK,
  input  logic              IO_VGA_RST,
  output logic [ADDR_W-1:0] IO_VGA_ADDR,
  input  logic [RGB_W-1:0]  IO_VGA_DATA,
  output logic [CH_W-1:0]   VGA_R,
  output logic [CH_W-1:0]   VGA_G,
  output logic [CH_W-1:0]   VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_DE,
  output logic              FRAME_START
);

  localparam int unsigned LINE_LEN    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned FRAME_LINES = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W         = cnt_w(LINE_LEN);
  localparam int unsigned V_W         = cnt_w(FRAME_LINES);
  localparam int unsigned HS_BEG      = H_VIS + H_FP;
  localparam int unsigned HS_END      = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG      = V_VIS + V_FP;
  localparam int unsigned VS_END      = VS_BEG + V_SYNC;
  // Address reg + RAM + pin reg; the pin register is the last control stage.
  localparam int unsigned PIPE_L      = RD_LAT + 2;
  localparam int unsigned CTL_DEPTH   = PIPE_L - 1;

  logic [H_W-1:0]    r_h;
  logic [V_W-1:0]    r_v;
  logic [ADDR_W-1:0] r_p;
  logic [ADDR_W-1:0] r_addr;
  logic [RGB_W-1:0]  r_rgb;
  logic              r_hs;
  logic              r_vs;
  logic              r_de;
  logic              r_fs;
  scan_ctl_t         w_ctl;
  scan_ctl_t         w_ctl_d;

  always_ff @(posedge IO_VGA_CLK or posedge IO_VGA_RST) begin
    if (IO_VGA_RST) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_W'(LINE_LEN - 1)) begin
      r_h <= '0;
      if (r_v == V_W'(FRAME_LINES - 1)) r_v <= '0;
      else                              r_v <= r_v + V_W'(1);
    end else begin
      r_h <= r_h + H_W'(1);
    end
  end

  // Raw timing decoded from the counter stage.
  always_comb begin
    w_ctl     = CTL_IDLE;
    w_ctl.vis = (r_h < H_W'(H_VIS)) && (r_v < V_W'(V_VIS));
    w_ctl.hs  = ((r_h >= H_W'(HS_BEG)) && (r_h < H_W'(HS_END))) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    w_ctl.vs  = ((r_v >= V_W'(VS_BEG)) && (r_v < V_W'(VS_END))) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    w_ctl.fs  = (r_h == '0) && (r_v == '0);
  end

  // Linear pointer: frame start fetches word 0 directly and primes the next one.
  always_ff @(posedge IO_VGA_CLK or posedge IO_VGA_RST) begin
    if (IO_VGA_RST) begin
      r_p    <= '0;
      r_addr <= '0;
    end else if (w_ctl.fs) begin
      r_addr <= '0;
      r_p    <= ADDR_W'(1);
    end else if (w_ctl.vis) begin
      r_addr <= r_p;
      r_p    <= r_p + ADDR_W'(1);
    end
  end

  vga_delay_line #(
    .WIDTH   (CTL_W),
    .DEPTH   (CTL_DEPTH),
    .RST_VAL (CTL_IDLE)
  ) u_ctl_dly (
    .i_clk (IO_VGA_CLK),
    .i_rst (IO_VGA_RST),
    .i_d   (w_ctl),
    .o_q   (w_ctl_d)
  );

  // Pin stage: data is only sampled on visible pixels so blanking is always black.
  always_ff @(posedge IO_VGA_CLK or posedge IO_VGA_RST) begin
    if (IO_VGA_RST) begin
      r_rgb <= '0;
      r_hs  <= ~SYNC_ACTIVE;
      r_vs  <= ~SYNC_ACTIVE;
      r_de  <= 1'b0;
      r_fs  <= 1'b0;
    end else begin
      r_rgb <= w_ctl_d.vis ? IO_VGA_DATA : '0;
      r_hs  <= w_ctl_d.hs;
      r_vs  <= w_ctl_d.vs;
      r_de  <= w_ctl_d.vis;
      r_fs  <= w_ctl_d.fs;
    end
  end

  assign IO_VGA_ADDR = r_addr;
  assign VGA_R       = r_rgb[11:8];
  assign VGA_G       = r_rgb[7:4];
  assign VGA_B       = r_rgb[3:0];
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_DE      = r_de;
  assign FRAME_START = r_fs;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: reduced timing, RD_LAT=1 and RD_LAT=2 instances side by side.
module tb_vga_scan_ctrl;

  localparam int HV = 16, HF = 2, HSW = 3, HB = 3;
  localparam int VV = 6,  VF = 1, VSW = 2, VB = 2;
  localparam int HT = HV + HF + HSW + HB;   // 24
  localparam int VT = VV + VF + VSW + VB;   // 11
  localparam int FR = HT * VT;              // 264

  logic        clk;
  logic        rst;
  bit          mode;   // 0: RAM word = addr[11:0], 1: constant 12'hFFF
  bit          rec;
  int          n_tests, n_fail;
  int          e;
  logic [18:0] m_addr;

  logic [18:0] addr1, addr2;
  logic [11:0] data1, data2, q1, q2a, q2b;
  logic [3:0]  r1, g1, b1, r2, g2, b2;
  logic        hs1, vs1, de1, fs1, hs2, vs2, de2, fs2;
  logic [15:0] p1, p2;

  int          fs1_q[$], fs2_q[$];
  int          hs_lo, vs_lo, de_ff1, de_ff2;
  logic [11:0] px_a, px_b, px_c, px_c2;
  logic [18:0] ad_z, ad_a, ad_b, ad_c, ad_d, ad_e;

  vga_scan_ctrl #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .RD_LAT(1)
  ) u_dut1 (
    .IO_VGA_CLK(clk), .IO_VGA_RST(rst), .IO_VGA_ADDR(addr1), .IO_VGA_DATA(data1),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1),
    .VGA_DE(de1), .FRAME_START(fs1)
  );

  vga_scan_ctrl #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .RD_LAT(2)
  ) u_dut2 (
    .IO_VGA_CLK(clk), .IO_VGA_RST(rst), .IO_VGA_ADDR(addr2), .IO_VGA_DATA(data2),
    .VGA_R(r2), .VGA_G(g2), .VGA_B(b2), .VGA_HS(hs2), .VGA_VS(vs2),
    .VGA_DE(de2), .FRAME_START(fs2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [11:0] ram_f(input logic [18:0] a);
    return mode ? 12'hFFF : a[11:0];
  endfunction

  // Synchronous VRAM models with one and two cycles of read latency.
  always @(posedge clk) begin
    q1  <= ram_f(addr1);
    q2a <= ram_f(addr2);
    q2b <= q2a;
  end
  assign data1 = q1;
  assign data2 = q2b;

  assign p1 = {de1, hs1, vs1, fs1, r1, g1, b1};
  assign p2 = {de2, hs2, vs2, fs2, r2, g2, b2};

  function automatic bit vis_of(input int k);
    if (k < 0) return 1'b0;
    return ((k % HT) < HV) && (((k / HT) % VT) < VV);
  endfunction

  function automatic int pix_of(input int k);
    return ((k / HT) % VT) * HV + (k % HT);
  endfunction

  // Expected pins {de,hs,vs,fs,rgb} for scan position k (k<0: still in the reset image).
  function automatic logic [15:0] exp_pins(input int k);
    int  h, v;
    bit  vis, hs, vs, fs;
    logic [11:0] rgb;
    if (k < 0) return 16'h6000;
    h   = k % HT;
    v   = (k / HT) % VT;
    vis = (h < HV) && (v < VV);
    hs  = !((h >= HV + HF) && (h < HV + HF + HSW));
    vs  = !((v >= VV + VF) && (v < VV + VF + VSW));
    fs  = (h == 0) && (v == 0);
    rgb = vis ? (mode ? 12'hFFF : 12'(v * HV + h)) : 12'h000;
    return {vis, hs, vs, fs, rgb};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_stats();
    fs1_q.delete();
    fs2_q.delete();
    hs_lo = 0; vs_lo = 0; de_ff1 = 0; de_ff2 = 0;
    px_a = 12'hEEE; px_b = 12'hEEE; px_c = 12'hEEE; px_c2 = 12'hEEE;
    ad_z = 19'h7FFFF; ad_a = 19'h7FFFF; ad_b = 19'h7FFFF;
    ad_c = 19'h7FFFF; ad_d = 19'h7FFFF; ad_e = 19'h7FFFF;
  endtask

  // Per-cycle compare against the model, sampled after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      e      = 0;
      m_addr = '0;
      chk("rst_addr1", 32'(addr1), 32'd0);
      chk("rst_addr2", 32'(addr2), 32'd0);
      chk("rst_pins1", 32'(p1), 32'h6000);
      chk("rst_pins2", 32'(p2), 32'h6000);
    end else begin
      e++;
      if (vis_of(e - 1)) m_addr = 19'(pix_of(e - 1));
      chk("addr1", 32'(addr1), 32'(m_addr));
      chk("addr2", 32'(addr2), 32'(m_addr));
      chk("pins1", 32'(p1), 32'(exp_pins(e - 3)));
      chk("pins2", 32'(p2), 32'(exp_pins(e - 4)));
      if (rec) begin
        if (fs1) fs1_q.push_back(e);
        if (fs2) fs2_q.push_back(e);
        if (e - 3 >= 0 && e - 3 < HT && !hs1) hs_lo++;
        if (e - 3 >= 0 && e - 3 < FR && !vs1) vs_lo++;
        if (e - 3 >= 0 && e - 3 < FR && de1 && p1[11:0] == 12'hFFF) de_ff1++;
        if (e - 4 >= 0 && e - 4 < FR && de2 && p2[11:0] == 12'hFFF) de_ff2++;
        if (e - 3 == 15)  px_a  = p1[11:0];
        if (e - 3 == HT)  px_b  = p1[11:0];
        if (e - 3 == 135) px_c  = p1[11:0];
        if (e - 4 == 135) px_c2 = p2[11:0];
        if (e == 1)   ad_z = addr1;
        if (e == 16)  ad_a = addr1;
        if (e == 17)  ad_b = addr1;
        if (e == 25)  ad_c = addr1;
        if (e == FR)  ad_d = addr1;
        if (e == FR + 1) ad_e = addr1;
      end
    end
  end

  initial begin
    bit found;
    n_tests = 0;
    n_fail  = 0;
    mode    = 1'b0;
    rec     = 1'b0;
    rst     = 1'b1;
    clr_stats();

    // Free run over two frames with the address-pattern RAM.
    repeat (4) @(negedge clk);
    rec = 1'b1;
    rst = 1'b0;
    repeat (2 * FR + 10) @(negedge clk);
    rec = 1'b0;
    chk("fs1_count", 32'(fs1_q.size()), 32'd3);
    chk("fs2_count", 32'(fs2_q.size()), 32'd3);
    if (fs1_q.size() >= 2) begin
      chk("fs1_first", 32'(fs1_q[0]), 32'd3);
      chk("fs1_period", 32'(fs1_q[1] - fs1_q[0]), 32'd264);
    end
    if (fs2_q.size() >= 1) chk("fs2_first", 32'(fs2_q[0]), 32'd4);
    chk("hs_low_per_line", 32'(hs_lo), 32'd3);
    chk("vs_low_per_frame", 32'(vs_lo), 32'd48);
    chk("pix_15_0", 32'(px_a), 32'h00F);
    chk("pix_0_1", 32'(px_b), 32'h010);
    chk("pix_last", 32'(px_c), 32'h05F);
    chk("pix_last_lat2", 32'(px_c2), 32'h05F);
    chk("addr_first", 32'(ad_z), 32'd0);
    chk("addr_eol", 32'(ad_a), 32'd15);
    chk("addr_hold", 32'(ad_b), 32'd15);
    chk("addr_line1", 32'(ad_c), 32'd16);
    chk("addr_last", 32'(ad_d), 32'd95);
    chk("addr_wrap", 32'(ad_e), 32'd0);

    // Mid-frame reset at h=10, v=3 of the counter stage.
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (e % FR == 3 * HT + 10) begin
        found = 1'b1;
        break;
      end
    end
    chk("midframe_reach", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_addr1", 32'(addr1), 32'd0);
    chk("async_pins1", 32'(p1), 32'h6000);
    chk("async_pins2", 32'(p2), 32'h6000);
    repeat (5) @(negedge clk);
    clr_stats();
    rec = 1'b1;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    rec = 1'b0;
    chk("mid_fs1_count", 32'(fs1_q.size()), 32'd1);
    if (fs1_q.size() >= 1) chk("mid_fs1_first", 32'(fs1_q[0]), 32'd3);
    if (fs2_q.size() >= 1) chk("mid_fs2_first", 32'(fs2_q[0]), 32'd4);
    chk("mid_addr_restart", 32'(ad_z), 32'd0);

    // Blanking with a constant all-ones data bus.
    rst  = 1'b1;
    mode = 1'b1;
    repeat (3) @(negedge clk);
    clr_stats();
    rec = 1'b1;
    rst = 1'b0;
    repeat (FR + 10) @(negedge clk);
    rec = 1'b0;
    chk("de_fff_count1", 32'(de_ff1), 32'd96);
    chk("de_fff_count2", 32'(de_ff2), 32'd96);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
